// File: rtl/pipeline_stage_pkg.sv
// Shared types and constants for the pipeline channel stages.
// Holds the stage FSM encoding, the default data width and the counter sizing helper.
package pipeline_stage_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        HALT  = 2'd3
    } stage_state_e;

    localparam int DATA_W = 32;

    // Bits needed to count from 0 up to and including count.
    function automatic int items_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/pipeline_scale_stage_if.sv
// Valid/ready channel bundle used between pipeline stages and FIFOs.
// Ports: data (W bits) and valid flow master->slave; ready flows slave->master.
interface pipeline_scale_stage_if #(
    parameter int W = 32
) ();

    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/pipeline_out_slot.sv
// Single-entry valid/ready output register shared by the channel stages.
// Ports: clk, rst (async low), load/load_data in, data/valid/ready channel out, free.
module pipeline_out_slot
    import pipeline_stage_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         valid,
    input  logic         ready,
    output logic         free
);

    logic fire;

    assign fire = valid && ready;
    // Slot can take a new word if empty or if its current word leaves this edge.
    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (fire) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_scale_stage.sv
// Scale stage: pops words, emits x*SCALE+OFFSET, then one done token after COUNT items.
// Ports: clk, rst (async low), in_ch (slave), out_ch/done_ch (master), sum, items.
module pipeline_scale_stage
    import pipeline_stage_pkg::*;
#(
    parameter int               WIDTH  = DATA_W,
    parameter int               COUNT  = 8,
    parameter logic [WIDTH-1:0] SCALE  = WIDTH'(3),
    parameter logic [WIDTH-1:0] OFFSET = WIDTH'(1),
    localparam int              IW     = items_width(COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_scale_stage_if.slave  in_ch,
    pipeline_scale_stage_if.master out_ch,
    pipeline_scale_stage_if.master done_ch,
    output logic [WIDTH-1:0]       sum,
    output logic [IW-1:0]          items
);

    stage_state_e     state;
    stage_state_e     state_nxt;
    logic             in_rdy;
    logic             accept;
    logic             last;
    logic             done_v;
    logic             slot_free;
    logic             slot_valid;
    logic [WIDTH-1:0] slot_data;
    logic [WIDTH-1:0] r;

    // Full-width product, then keep the low WIDTH bits.
    assign r = WIDTH'(({{WIDTH{1'b0}}, in_ch.data} * {{WIDTH{1'b0}}, SCALE})
                      + {{WIDTH{1'b0}}, OFFSET});

    assign in_rdy = rst && (state == RUN) && slot_free;
    assign accept = in_ch.valid && in_rdy;
    assign last   = (items == IW'(COUNT - 1));

    assign in_ch.ready   = in_rdy;
    assign out_ch.data   = slot_data;
    assign out_ch.valid  = slot_valid;
    assign done_ch.valid = done_v;
    assign done_ch.data  = done_v;

    pipeline_out_slot #(
        .W (WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (r),
        .data      (slot_data),
        .valid     (slot_valid),
        .ready     (out_ch.ready),
        .free      (slot_free)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_v    = 1'b0;
        unique case (state)
            RUN: begin
                if (accept && last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_v = 1'b1;
                if (done_ch.ready) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Observation counters advance on accept, not on output transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum   <= '0;
            items <= '0;
        end else if (accept) begin
            sum   <= sum + r;
            items <= items + IW'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_scale_stage.sv
// Scoreboard bench for pipeline_scale_stage: directed scenarios plus random traffic.
// Expected results come from plain arithmetic on the driven inputs.
module tb_pipeline_scale_stage;

    logic        clk;
    logic        rst;
    logic [31:0] sum;
    logic [3:0]  items;

    pipeline_scale_stage_if #(.W(32)) in_ch ();
    pipeline_scale_stage_if #(.W(32)) out_ch ();
    pipeline_scale_stage_if #(.W(1))  done_ch ();

    pipeline_scale_stage dut (
        .clk     (clk),
        .rst     (rst),
        .in_ch   (in_ch),
        .out_ch  (out_ch),
        .done_ch (done_ch),
        .sum     (sum),
        .items   (items)
    );

    int          checks;
    int          errors;
    int          outs;
    int          tokens;
    logic [31:0] sb[$];
    logic [31:0] exp_sum;
    int          exp_items;
    logic [31:0] last_r;
    bit          rand_ready;
    bit          stalled;
    logic [31:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk_eq(input string name, input logic [31:0] act,
                                   input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_accept(input logic [31:0] x);
        logic [63:0] p;
        p = {32'd0, x} * 64'd3 + 64'd1;
        last_r = p[31:0];
        sb.push_back(last_r);
        exp_sum = exp_sum + last_r;
        exp_items++;
    endfunction

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk_eq("hold_valid", 32'(out_ch.valid), 1);
                chk_eq("hold_data", out_ch.data, held);
            end
            if (out_ch.valid && !out_ch.ready)
                chk_eq("stall_in_ready", 32'(in_ch.ready), 0);
            if (out_ch.valid && out_ch.ready) begin
                outs++;
                if (sb.size() == 0)
                    chk_eq("sb_depth", 32'(sb.size()), 1);
                else
                    chk_eq("out_data", out_ch.data, sb.pop_front());
            end
            stalled = out_ch.valid && !out_ch.ready;
            held    = out_ch.data;
            if (done_ch.valid) begin
                chk_eq("done_data", 32'(done_ch.data), 1);
                if (done_ch.ready) tokens++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ch.ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        #2;
        rst           = 1'b0;
        rand_ready    = 1'b0;
        in_ch.valid   = 1'b0;
        in_ch.data    = '0;
        out_ch.ready  = 1'b1;
        done_ch.ready = 1'b1;
        #1;
        chk_eq("rst_out_valid", 32'(out_ch.valid), 0);
        chk_eq("rst_out_data", out_ch.data, 0);
        chk_eq("rst_done_valid", 32'(done_ch.valid), 0);
        chk_eq("rst_sum", sum, 0);
        chk_eq("rst_items", 32'(items), 0);
        chk_eq("rst_in_ready", 32'(in_ch.ready), 0);
        sb.delete();
        exp_sum   = '0;
        exp_items = 0;
        outs      = 0;
        tokens    = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic send(input logic [31:0] x, input int budget);
        bit got;
        got         = 1'b0;
        in_ch.valid = 1'b1;
        in_ch.data  = x;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (in_ch.ready) begin
                got = 1'b1;
                model_accept(x);
            end
            @(posedge clk);
            #1;
        end
        in_ch.valid = 1'b0;
        chk_eq("accepted", 32'(got), 1);
        if (got) begin
            chk_eq("lat_valid", 32'(out_ch.valid), 1);
            chk_eq("lat_data", out_ch.data, last_r);
            chk_eq("sum", sum, exp_sum);
            chk_eq("items", 32'(items), 32'(exp_items));
        end
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && !done_ch.valid; n++)
            @(negedge clk);
        chk_eq("done_seen", 32'(done_ch.valid), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_run();
        wait_done(60);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("outs", 32'(outs), 32'(exp_items));
        chk_eq("tokens", 32'(tokens), 1);
        chk_eq("sb_empty", 32'(sb.size()), 0);
        chk_eq("end_sum", sum, exp_sum);
        chk_eq("end_items", 32'(items), 32'(exp_items));
        chk_eq("end_done_valid", 32'(done_ch.valid), 0);
        chk_eq("end_in_ready", 32'(in_ch.ready), 0);
    endtask

    task automatic stream();
        for (int i = 0; i < 8; i++) send(32'(i), 1);
        chk_eq("stream_sum", sum, 32'd92);
        chk_eq("stream_items", 32'(items), 8);
        finish_run();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        do_reset();

        // streaming
        stream();

        // backpressure on the output of input 5
        do_reset();
        for (int i = 0; i < 6; i++) send(32'(i), 1);
        out_ch.ready = 1'b0;
        in_ch.valid  = 1'b1;
        in_ch.data   = 32'd6;
        repeat (5) begin
            @(negedge clk);
            chk_eq("bp_data", out_ch.data, 32'd16);
            chk_eq("bp_valid", 32'(out_ch.valid), 1);
            chk_eq("bp_in_ready", 32'(in_ch.ready), 0);
        end
        @(posedge clk);
        #1;
        out_ch.ready = 1'b1;
        send(32'd6, 1);
        send(32'd7, 1);
        finish_run();

        // wrap-around
        do_reset();
        send(32'hFFFF_FFFF, 1);
        chk_eq("wrap_hi", out_ch.data, 32'hFFFF_FFFE);
        send(32'h0, 1);
        chk_eq("wrap_lo", out_ch.data, 32'h0000_0001);
        chk_eq("wrap_sum", sum, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) send($urandom, 1);
        finish_run();

        // completion hold
        do_reset();
        done_ch.ready = 1'b0;
        for (int i = 0; i < 8; i++) send($urandom, 1);
        wait_done(10);
        in_ch.valid = 1'b1;
        in_ch.data  = $urandom;
        repeat (4) begin
            @(negedge clk);
            chk_eq("hold_done_valid", 32'(done_ch.valid), 1);
            chk_eq("hold_in_ready", 32'(in_ch.ready), 0);
        end
        @(posedge clk);
        #1;
        done_ch.ready = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("halt_done_valid", 32'(done_ch.valid), 0);
        chk_eq("halt_tokens", 32'(tokens), 1);
        repeat (20) begin
            @(negedge clk);
            chk_eq("halt_in_ready", 32'(in_ch.ready), 0);
            chk_eq("halt_items", 32'(items), 8);
        end
        in_ch.valid = 1'b0;

        // reset mid-operation, then a fresh run
        do_reset();
        for (int i = 0; i < 3; i++) send(32'(i), 1);
        do_reset();
        stream();

        // sparse input
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(32'(i), 1);
            @(posedge clk);
            #1;
        end
        chk_eq("sparse_sum", sum, 32'd92);
        finish_run();

        // random data, gaps and output backpressure
        repeat (3) begin
            do_reset();
            rand_ready = 1'b1;
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send($urandom, 60);
            end
            finish_run();
            rand_ready = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_scale_stage.md
Name: pipeline_scale_stage

Overview:
Channel-consuming compute stage for the pipeline1 flow. It sits directly downstream of a 32-bit channel FIFO: it pops words from that FIFO's output side, applies y = x*SCALE + OFFSET, and pushes each result into the next 32-bit channel FIFO's input side. After COUNT items it emits a single 1-bit completion token on a bool channel, which feeds a depth-1 FIFO, then halts. It also keeps a running sum of the results for observation.

Parameters:
WIDTH, 32, data width of the input and output channels
COUNT, 8, number of items processed before completion; must be >= 1
SCALE, 3, multiplier constant, WIDTH bits
OFFSET, 1, additive constant, WIDTH bits

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; asynchronous, active-low (asserted at 0)
in_data  input  WIDTH  word from the upstream FIFO's out_data
in_valid  input  1  upstream FIFO's out_valid
in_ready  output  1  pop strobe to the upstream FIFO's out_ready
out_data  output  WIDTH  result to the downstream FIFO's in_data
out_valid  output  1  result valid
out_ready  input  1  downstream FIFO's in_ready
done_data  output  1  completion token value; constant 1 while done_valid
done_valid  output  1  completion token valid
done_ready  input  1  completion FIFO's in_ready
sum  output  WIDTH  running sum of all results accepted so far
items  output  $clog2(COUNT+1)  number of inputs accepted

Behaviour:
- Reset (rst=0, async) sets: state=RUN, out_valid=0, out_data=0, done_valid=0, sum=0, items=0. in_ready is combinational and is 0 during reset.
- The block owns a single output register slot. A transfer happens on any channel when valid && ready are both high at a rising edge.
- States:
  - RUN: in_ready = !out_valid || out_ready. This gives full throughput under continuous flow.
  - DRAIN: in_ready=0. Wait until the slot is empty (out_valid=0) or empties this cycle (out_ready=1).
  - DONE: done_valid=1, done_data=1. Move to HALT when done_ready=1.
  - HALT: in_ready=0, out_valid=0, done_valid=0. Stay here until reset.
- On accept in RUN:
  - r = (in_data*SCALE + OFFSET) mod 2^WIDTH. Compute in 2*WIDTH bits, then truncate.
  - out_data<=r, out_valid<=1, sum<=(sum+r) mod 2^WIDTH, items<=items+1.
  - Latency: exactly 1 cycle from accept to out_valid.
- Output fires with no accept in the same cycle: out_valid<=0, out_data holds.
- Simultaneous output fire and input accept: the slot is overwritten with the new r, and out_valid stays 1. This is not a bubble.
- Transition RUN->DRAIN happens on the accept that makes items==COUNT. No further input is accepted after that point.
- Transition DRAIN->DONE happens at the edge where the slot is empty or firing. done_valid rises the cycle after the last output transfer, or immediately if the slot was already empty.
- While out_valid=1 and out_ready=0: out_data and out_valid are stable, and in_ready=0.
- in_data is ignored whenever in_valid=0 or in_ready=0.
- Reset asserted mid-operation: all state is cleared immediately. Any in-flight out_valid or done_valid drops asynchronously. Sum and count restart from 0.
- sum and items are registered outputs. They update on the accept edge, not on the output transfer.

Decomposition:
- Shared package pipeline_stage_pkg holds:
  - state enum {RUN, DRAIN, DONE, HALT}, 2 bits
  - default data width constant (32)
  - function for the items-counter width, clog2(COUNT+1)
- One natural sub-module: pipeline_out_slot.
  - Contents: single-entry valid/ready holding register, with load, fire and stall logic.
  - Reuse: other channel stages use it too.
- FSM, arithmetic and counters stay in pipeline_scale_stage.

Test Plan:
- Streaming: defaults, in_valid held 1 with inputs 0..7, out_ready=1.
  - Outputs 1,4,7,10,13,16,19,22 on consecutive cycles, each 1 cycle after its accept.
  - Final sum=92, items=8, done_valid=1 with done_data=1.
- Backpressure: out_ready=0 for 5 cycles after the first accept of input 5.
  - out_data=16 held stable, in_ready=0 throughout.
  - On release, 16 transfers and the next input is accepted in the same cycle.
- Wrap-around: input 0xFFFFFFFF followed by input 0.
  - out_data=0xFFFFFFFE, then 0x00000001.
  - sum=0xFFFFFFFF, with no carry out.
- Completion hold: after 8 items, keep done_ready=0 for 4 cycles.
  - done_valid stays 1 and in_ready stays 0 even with in_valid=1.
  - done_ready=1 -> one token transferred, HALT entered, done_valid=0, and no inputs accepted for 20 further cycles.
- Reset mid-operation: drive rst=0 asynchronously (between edges) after 3 items, while out_valid=1.
  - out_valid=0, sum=0 and items=0 immediately.
  - After release, a fresh 8-item run produces the same results as the Streaming scenario.
- Sparse input: in_valid toggled 1/0 every cycle with inputs 0..7.
  - out_valid pulses track each accept with 1-cycle latency.
  - Total outputs=8 and exactly one done token.
